// File: rtl/case_7_mul_arb_pkg.sv
// rtl/case_7_mul_arb_pkg.sv - shared widths, saturation limits and S1 bundle type for case_7
package case_7_mul_arb_pkg;

  localparam int A_WIDTH    = 10;
  localparam int B_WIDTH    = 8;
  localparam int P_WIDTH    = 13;
  localparam int FULL_WIDTH = A_WIDTH + B_WIDTH;

  localparam int P_MAX = 4095;
  localparam int P_MIN = -4096;

  // Operand bundle held in S1 for the default widths (id wide enough for 8 requesters)
  typedef struct packed {
    logic signed [A_WIDTH-1:0] a;
    logic signed [B_WIDTH-1:0] b;
    logic        [2:0]         id;
  } s1_op_t;

endpackage

// File: rtl/case_7_mul_rr_arb.sv
// rtl/case_7_mul_rr_arb.sv - round-robin arbiter owning the last-grant pointer
module case_7_mul_rr_arb #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                en,
  input  logic                upd,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx
);

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] cand;
  logic                found;

  // Search from ptr+1 upward with wrap; first valid requester wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  // Pointer moves to the winner only on a completed handshake
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr <= ID_WIDTH'(NUM_REQ - 1);
    end else if (upd) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/case_7_mul_share_arb.sv
// rtl/case_7_mul_share_arb.sv - one signed multiplier shared by NUM_REQ requesters (saturation: CASE_7_MUL_ARB_SAT_EN)
module case_7_mul_share_arb #(
  parameter  int NUM_REQ  = 4,
  parameter  int A_WIDTH  = case_7_mul_arb_pkg::A_WIDTH,
  parameter  int B_WIDTH  = case_7_mul_arb_pkg::B_WIDTH,
  parameter  int P_WIDTH  = case_7_mul_arb_pkg::P_WIDTH,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [P_WIDTH-1:0]          rsp_data,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic                        rsp_sat,
  output logic                        busy
);

  localparam int FULL_WIDTH = A_WIDTH + B_WIDTH;

  logic                s2_adv;
  logic                s1_adv;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                hs;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;
  logic                s1_valid;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;
  logic [ID_WIDTH-1:0] s1_id;
  logic [P_WIDTH-1:0]  f_data;

  assign s2_adv    = !rsp_valid || rsp_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign busy      = s1_valid | rsp_valid;

  case_7_mul_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .req   (req_valid),
    .en    (s1_adv && !ap_rst),
    .upd   (hs),
    .grant (grant),
    .idx   (grant_idx)
  );

  // One-hot operand select of the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a = sel_a | (req_a[i*A_WIDTH +: A_WIDTH] & {A_WIDTH{grant[i]}});
      sel_b = sel_b | (req_b[i*B_WIDTH +: B_WIDTH] & {B_WIDTH{grant[i]}});
    end
  end

`ifdef CASE_7_MUL_ARB_SAT_EN
  localparam logic [P_WIDTH-1:0] SAT_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] SAT_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic signed [FULL_WIDTH-1:0] full;
  logic                         f_sat;

  // Out of range when the bits above the result sign are not a pure sign extension
  assign full   = $signed(s1_a) * $signed(s1_b);
  assign f_sat  = full[FULL_WIDTH-1:P_WIDTH-1] != {(FULL_WIDTH-P_WIDTH+1){full[FULL_WIDTH-1]}};
  assign f_data = f_sat ? (full[FULL_WIDTH-1] ? SAT_MIN : SAT_MAX) : full[P_WIDTH-1:0];
`else
  assign f_data  = P_WIDTH'(FULL_WIDTH'($signed(s1_a)) * FULL_WIDTH'($signed(s1_b)));
  assign rsp_sat = 1'b0;
`endif

  // S1 operand register: loads the granted request whenever S1 can advance
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= |grant;
      if (|grant) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= grant_idx;
      end
    end
  end

  // S2 output register: payload only changes when a valid operand moves in
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef CASE_7_MUL_ARB_SAT_EN
      rsp_sat   <= 1'b0;
`endif
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= f_data;
        rsp_id   <= s1_id;
`ifdef CASE_7_MUL_ARB_SAT_EN
        rsp_sat  <= f_sat;
`endif
      end
    end
  end

endmodule
